// File: rtl/spi_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl_if
//   Bundles the host write port, status flags, the SPI pins and the receive
//   result of spi_master_ctrl into one interface.
//
//   Signals:
//     wr_en, wr_data          host -> controller, push a word into the TX FIFO
//     full, busy, done        controller -> host status (registered)
//     spi_clk, spi_cs,
//     spi_mosi_out            controller -> SPI slave
//     spi_miso_in             SPI slave -> controller
//     rx_data, rx_valid       controller -> host, last received word
//
//   Modports:
//     master  the controller side (drives the SPI pins and status)
//     slave   the host / bench side (drives the write port and MISO)
// ---------------------------------------------------------------------------
interface spi_master_ctrl_if #(
    parameter int DSIZE = 8
) ();
    logic             wr_en;
    logic [DSIZE-1:0] wr_data;
    logic             full;
    logic             busy;
    logic             done;
    logic             spi_clk;
    logic             spi_cs;
    logic             spi_mosi_out;
    logic             spi_miso_in;
    logic [DSIZE-1:0] rx_data;
    logic             rx_valid;

    modport master (
        input  wr_en,
        input  wr_data,
        input  spi_miso_in,
        output full,
        output busy,
        output done,
        output spi_clk,
        output spi_cs,
        output spi_mosi_out,
        output rx_data,
        output rx_valid
    );

    modport slave (
        output wr_en,
        output wr_data,
        output spi_miso_in,
        input  full,
        input  busy,
        input  done,
        input  spi_clk,
        input  spi_cs,
        input  spi_mosi_out,
        input  rx_data,
        input  rx_valid
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
//   SPI mode-0 transmit controller. Host words are buffered in a small TX
//   FIFO and shifted out LSB-first on spi_mosi_out while spi_clk is divided
//   down from clk. Back-to-back queued words share one chip-select burst; a
//   one-cycle done pulse marks each completed word.
//
//   Ports:
//     clk   system clock, everything on its rising edge
//     rst   synchronous active-high reset; aborts any transfer, flushes FIFO
//     bus   spi_master_ctrl_if.master (write port, status, SPI pins, RX)
//
//   Parameters:
//     DSIZE       word width in bits (>= 2)
//     CLK_DIV     spi_clk half-period in clk cycles (>= 1)
//     FIFO_DEPTH  TX FIFO entries (power of two, >= 2)
//
//   Build option:
//     SPI_MASTER_CTRL_MISO_EN  when defined, spi_miso_in is sampled on every
//     spi_clk rise and the assembled word is published on rx_data with
//     rx_valid in the done cycle. Otherwise rx_data/rx_valid are tied to 0.
// ---------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int DSIZE      = 8,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_ctrl_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(DSIZE + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT_C = BIT_W'(DSIZE);
    localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_e;

    // TX FIFO
    logic [DSIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s;
    logic             pop_s;
    logic [DSIZE-1:0] head_s;

    // Sequencer
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;       // spi_clk rises seen in this word
    logic [DSIZE-1:0] tx_sh_q, tx_sh_d;   // bits not yet driven on MOSI
    logic             div_end_s;
    logic             rise_s;
    logic             word_end_s;

    // Registered outputs
    logic             sclk_q, sclk_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             full_q, full_d;

    // Next-state logic for the FIFO bookkeeping and the transfer sequencer.
    always_comb begin
        push_s     = bus.wr_en && (count_q < DEPTH_C);
        div_end_s  = (div_q == DIV_LAST_C);
        head_s     = mem_q[rd_ptr_q];

        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        done_d     = 1'b0;
        pop_s      = 1'b0;
        rise_s     = 1'b0;
        word_end_s = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                div_d  = '0;
                bit_d  = '0;
                if (count_q != '0) begin
                    pop_s   = 1'b1;
                    tx_sh_d = {1'b0, head_s[DSIZE-1:1]};
                    mosi_d  = head_s[0];
                    cs_d    = 1'b0;
                    state_d = SETUP;
                end else begin
                    cs_d    = 1'b1;
                    state_d = IDLE;
                end
            end

            // Bit0 is already on MOSI; one half-period of setup, then first rise.
            SETUP: begin
                if (div_end_s) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    bit_d   = bit_q + BIT_W'(1);
                    rise_s  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    div_d   = div_q + DIV_W'(1);
                end
            end

            // After the last fall the clock stays low one more half-period
            // before the word is declared finished.
            SHIFT: begin
                if (!div_end_s) begin
                    div_d = div_q + DIV_W'(1);
                end else if (sclk_q) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q != LAST_BIT_C) begin
                        mosi_d  = tx_sh_q[0];
                        tx_sh_d = {1'b0, tx_sh_q[DSIZE-1:1]};
                    end else begin
                        mosi_d  = mosi_q;
                    end
                end else if (bit_q == LAST_BIT_C) begin
                    div_d      = '0;
                    bit_d      = '0;
                    done_d     = 1'b1;
                    word_end_s = 1'b1;
                    if (count_q != '0) begin
                        // Burst: chain the next word without releasing CS.
                        pop_s   = 1'b1;
                        tx_sh_d = {1'b0, head_s[DSIZE-1:1]};
                        mosi_d  = head_s[0];
                        state_d = SETUP;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    div_d  = '0;
                    sclk_d = 1'b1;
                    bit_d  = bit_q + BIT_W'(1);
                    rise_s = 1'b1;
                end
            end

            HOLD: begin
                if (div_end_s) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    state_d = GAP;
                end else begin
                    div_d   = div_q + DIV_W'(1);
                end
            end

            GAP: begin
                if (div_end_s) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d   = div_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                div_d   = '0;
                bit_d   = '0;
                sclk_d  = 1'b0;
                cs_d    = 1'b1;
            end
        endcase

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        full_d   = (count_d == DEPTH_C);
        busy_d   = (state_d != IDLE) || (count_d != '0);
    end

    // State, FIFO pointers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            tx_sh_q  <= '0;
            sclk_q   <= 1'b0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_sh_q  <= tx_sh_d;
            sclk_q   <= sclk_d;
            cs_q     <= cs_d;
            mosi_q   <= mosi_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

`ifdef SPI_MASTER_CTRL_MISO_EN
    logic [DSIZE-1:0] rx_sh_q;
    logic [DSIZE-1:0] rx_data_q;
    logic             rx_valid_q;

    // Receive path: shift MISO in LSB-first on each rise, publish at word end.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            if (rise_s) begin
                rx_sh_q <= {bus.spi_miso_in, rx_sh_q[DSIZE-1:1]};
            end
            if (word_end_s) begin
                rx_data_q <= rx_sh_q;
            end
            rx_valid_q <= word_end_s;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`else
    logic unused_rx_s;
    assign unused_rx_s  = ^{bus.spi_miso_in, rise_s, word_end_s};
    assign bus.rx_data  = '0;
    assign bus.rx_valid = 1'b0;
`endif

    assign bus.spi_clk      = sclk_q;
    assign bus.spi_cs       = cs_q;
    assign bus.spi_mosi_out = mosi_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
    assign bus.full         = full_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl
//   Directed bench for spi_master_ctrl with DSIZE=8, CLK_DIV=2, FIFO_DEPTH=4.
//   MISO is looped back from MOSI; receive results are checked only when
//   SPI_MASTER_CTRL_MISO_EN is defined, otherwise rx outputs must stay 0.
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;
    localparam int DSIZE      = 8;
    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int WORD_CYC   = CLK_DIV * (2 * DSIZE + 1);   // 34

    typedef struct packed {
        logic [7:0] word;
        logic [7:0] seq;   // MOSI at successive rises, first rise in the MSB
        logic [7:0] rx;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    spi_master_ctrl_if #(.DSIZE(DSIZE)) bus ();

    spi_master_ctrl #(
        .DSIZE      (DSIZE),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.spi_miso_in = bus.spi_mosi_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled 1 time unit after each rising edge.
    int   cs_fall_q[$];
    int   cs_rise_q[$];
    int   done_q[$];
    int   rxv_q[$];
    logic rise_bits[$];
    logic [DSIZE-1:0] rx_q[$];
    logic mon_en      = 1'b0;
    logic prev_cs     = 1'b1;
    logic prev_clk    = 1'b0;
    int   clk_cs_high = 0;
    int   rx_nonzero  = 0;

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (bus.spi_cs !== prev_cs) begin
                if (bus.spi_cs === 1'b0) cs_fall_q.push_back(cyc);
                else                     cs_rise_q.push_back(cyc);
            end
            if (bus.spi_clk === 1'b1 && prev_clk === 1'b0) begin
                rise_bits.push_back(bus.spi_mosi_out);
                if (bus.spi_cs !== 1'b0) clk_cs_high <= clk_cs_high + 1;
            end
            if (bus.done === 1'b1) done_q.push_back(cyc);
            if (bus.rx_valid === 1'b1) begin
                rxv_q.push_back(cyc);
                rx_q.push_back(bus.rx_data);
            end
            if (bus.rx_data !== '0) rx_nonzero <= rx_nonzero + 1;
        end
        prev_cs  <= bus.spi_cs;
        prev_clk <= bus.spi_clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic clear_mon();
        cs_fall_q.delete();
        cs_rise_q.delete();
        done_q.delete();
        rxv_q.delete();
        rise_bits.delete();
        rx_q.delete();
    endtask

    task automatic push(input logic [7:0] w);
        bus.wr_en   = 1'b1;
        bus.wr_data = w;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) timeout_fail(name);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [63:0] pack_bits(input int first, input int count);
        logic [63:0] acc;
        acc = 64'd0;
        for (int k = first; k < first + count; k++) begin
            if (k < rise_bits.size()) acc = {acc[62:0], rise_bits[k]};
            else                      acc = {acc[62:0], 1'b1};
        end
        return acc;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   pc;
        int   n;
        int   bad;

        vecs[0] = '{word: 8'hA5, seq: 8'b1010_0101, rx: 8'hA5};
        vecs[1] = '{word: 8'h3C, seq: 8'b0011_1100, rx: 8'h3C};
        vecs[2] = '{word: 8'h01, seq: 8'b1000_0000, rx: 8'h01};
        vecs[3] = '{word: 8'hC8, seq: 8'b0001_0011, rx: 8'hC8};

        // ---------------- reset ----------------
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs",       bus.spi_cs,       1'b1);
        check("rst_sclk",     bus.spi_clk,      1'b0);
        check("rst_mosi",     bus.spi_mosi_out, 1'b0);
        check("rst_done",     bus.done,         1'b0);
        check("rst_busy",     bus.busy,         1'b0);
        check("rst_full",     bus.full,         1'b0);
        check("rst_rx_data",  bus.rx_data,      8'h00);
        check("rst_rx_valid", bus.rx_valid,     1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;
        bad    = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.spi_cs !== 1'b1 || bus.spi_clk !== 1'b0) bad++;
        end
        check("idle_lines", bad, 0);

        // ---------------- single words from the table ----------------
        for (int i = 0; i < 4; i++) begin
            clear_mon();
            pc = cyc;
            push(vecs[i].word);
            check("vec_busy", bus.busy, 1'b1);
            wait_idle(600, "vec_idle");
            check("vec_nfall", cs_fall_q.size(), 1);
            check("vec_nrise", rise_bits.size(), DSIZE);
            check("vec_ndone", done_q.size(), 1);
            check("vec_bits", pack_bits(0, 8), {56'd0, vecs[i].seq});
            if (cs_fall_q.size() > 0) check("vec_cs_lat", cs_fall_q[0] - pc, 2);
            if (cs_fall_q.size() > 0 && done_q.size() > 0)
                check("vec_done_lat", done_q[0] - cs_fall_q[0], WORD_CYC);
            if (cs_rise_q.size() > 0 && done_q.size() > 0)
                check("vec_cs_rise", cs_rise_q[0] - done_q[0], CLK_DIV);
`ifdef SPI_MASTER_CTRL_MISO_EN
            check("vec_nrx", rx_q.size(), 1);
            if (rx_q.size() > 0) check("vec_rx_data", rx_q[0], vecs[i].rx);
            if (rxv_q.size() > 0 && done_q.size() > 0)
                check("vec_rx_at_done", rxv_q[0], done_q[0]);
`else
            check("vec_no_rx", rxv_q.size(), 0);
`endif
        end

        // ---------------- burst of three, then one more after the gap ----------------
        clear_mon();
        push(8'h01);
        push(8'h02);
        push(8'h03);
        n = 0;
        while (done_q.size() < 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) timeout_fail("burst_wait");
        push(8'h5A);
        wait_idle(600, "burst_idle");
        check("burst_nfall", cs_fall_q.size(), 2);
        check("burst_nrise", rise_bits.size(), 32);
        check("burst_ndone", done_q.size(), 4);
        check("burst_bits", pack_bits(0, 24), 64'b10000000_01000000_11000000);
        if (done_q.size() >= 3) begin
            check("burst_sp1", done_q[1] - done_q[0], WORD_CYC);
            check("burst_sp2", done_q[2] - done_q[1], WORD_CYC);
        end
        if (cs_rise_q.size() > 0 && cs_fall_q.size() > 1)
            check("burst_gap", (cs_fall_q[1] - cs_rise_q[0]) >= CLK_DIV, 1'b1);
        if (cs_rise_q.size() > 0 && done_q.size() >= 3)
            check("burst_cs_rise", cs_rise_q[0] - done_q[2], CLK_DIV);

        // ---------------- overflow ----------------
        clear_mon();
        push(8'hEE);
        n = 0;
        while (bus.spi_cs !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout_fail("ovf_start");
        push(8'h10);
        push(8'h11);
        push(8'h12);
        check("ovf_not_full3", bus.full, 1'b0);
        push(8'h13);
        check("ovf_full", bus.full, 1'b1);
        push(8'h14);
        check("ovf_full_hold", bus.full, 1'b1);
        check("ovf_busy", bus.busy, 1'b1);
        wait_idle(1000, "ovf_idle");
        check("ovf_ndone", done_q.size(), 5);
        check("ovf_nrise", rise_bits.size(), 40);
        check("ovf_nfall", cs_fall_q.size(), 1);
        check("ovf_bits", pack_bits(0, 40),
              64'b01110111_00001000_10001000_01001000_11001000);
        check("ovf_full_end", bus.full, 1'b0);

        // ---------------- reset mid-word ----------------
        clear_mon();
        push(8'hC3);
        push(8'h5A);
        push(8'h81);
        n = 0;
        while (rise_bits.size() < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout_fail("mid_wait");
        rst = 1'b1;
        @(negedge clk);
        check("mid_cs",   bus.spi_cs,  1'b1);
        check("mid_sclk", bus.spi_clk, 1'b0);
        check("mid_busy", bus.busy,    1'b0);
        check("mid_full", bus.full,    1'b0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_ndone", done_q.size(), 0);
        check("mid_nfall", cs_fall_q.size(), 1);
        check("mid_nrise", rise_bits.size(), 4);
        check("mid_busy_after", bus.busy, 1'b0);
        check("mid_cs_after", bus.spi_cs, 1'b1);

        // ---------------- global properties ----------------
        check("clk_while_cs_high", clk_cs_high, 0);
`ifndef SPI_MASTER_CTRL_MISO_EN
        check("rx_tied_zero", rx_nonzero, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
